// File: rtl/ping_pong_sched_pkg.sv
// Shared types and widths for the ping-pong write scheduler and its round-robin picker.
package ping_pong_sched_pkg;

  // Holds 0..254, enough for any legal BURST_LEN up to 255.
  localparam int BURST_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } sched_state_e;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_e;

endpackage

// File: rtl/pp_rr_pick.sv
// Two-way round-robin pick: on a tie, the requester not served last wins.
module pp_rr_pick
  import ping_pong_sched_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
  input  src_e last_served,
  output logic win_valid,
  output src_e winner
);

  always_comb begin
    win_valid = req_a | req_b;
    winner    = SRC_A;
    if (req_a && req_b) begin
      winner = (last_served == SRC_A) ? SRC_B : SRC_A;
    end else if (req_b) begin
      winner = SRC_B;
    end
  end

endmodule

// File: rtl/ping_pong_write_scheduler.sv
// Arbitrates two beat requesters onto one ping-pong buffer write port in bounded bursts.
// Optional per-requester accepted-beat counters are added when PP_SCHED_STATS_EN is defined.
//
//   state   | meaning
//   IDLE    | no owner; pick a requester via round-robin
//   GRANT_A | A owns the write port until BURST_LEN beats or req_a drops
//   GRANT_B | B owns the write port until BURST_LEN beats or req_b drops
module ping_pong_write_scheduler
  import ping_pong_sched_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_a,
  input  logic              req_b,
  input  logic              valid_a,
  input  logic              valid_b,
  input  logic [DATA_W-1:0] data_a,
  input  logic [DATA_W-1:0] data_b,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic              ready_a,
  output logic              ready_b,
  input  logic              write_full,
  output logic              write_en,
  output logic [DATA_W-1:0] write_data,
  output logic              busy
`ifdef PP_SCHED_STATS_EN
  ,
  output logic [15:0]       beat_cnt_a,
  output logic [15:0]       beat_cnt_b
`endif
);

  localparam logic [BURST_CNT_W-1:0] LAST_BEAT = BURST_CNT_W'(BURST_LEN - 1);

  sched_state_e            state, state_nxt;
  src_e                    last_served, last_nxt;
  logic [BURST_CNT_W-1:0]  burst_cnt;
  logic                    pick_valid;
  src_e                    pick;
  logic                    accept;
  logic                    burst_done;

  pp_rr_pick u_pick (
    .req_a       (req_a),
    .req_b       (req_b),
    .last_served (last_served),
    .win_valid   (pick_valid),
    .winner      (pick)
  );

  // Every state change is a grant change, so the burst counter clears on it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      last_served <= SRC_B;
      burst_cnt   <= '0;
    end else begin
      state       <= state_nxt;
      last_served <= last_nxt;
      if (state_nxt != state) begin
        burst_cnt <= '0;
      end else if (accept) begin
        burst_cnt <= burst_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    last_nxt   = last_served;
    burst_done = accept && (burst_cnt == LAST_BEAT);
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_nxt = (pick == SRC_A) ? GRANT_A : GRANT_B;
          last_nxt  = pick;
        end
      end
      GRANT_A: begin
        if (burst_done || !req_a) begin
          if (req_b) begin
            state_nxt = GRANT_B;
            last_nxt  = SRC_B;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      GRANT_B: begin
        if (burst_done || !req_b) begin
          if (req_a) begin
            state_nxt = GRANT_A;
            last_nxt  = SRC_A;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt_a      = (state == GRANT_A);
    gnt_b      = (state == GRANT_B);
    busy       = (state != IDLE);
    ready_a    = gnt_a && !write_full;
    ready_b    = gnt_b && !write_full;
    write_en   = 1'b0;
    write_data = '0;
    if (gnt_a) begin
      write_en   = valid_a && ready_a;
      write_data = data_a;
    end else if (gnt_b) begin
      write_en   = valid_b && ready_b;
      write_data = data_b;
    end
    accept = write_en;
  end

`ifdef PP_SCHED_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt_a <= '0;
      beat_cnt_b <= '0;
    end else if (accept) begin
      if (gnt_a && (beat_cnt_a != 16'hFFFF)) beat_cnt_a <= beat_cnt_a + 16'd1;
      if (gnt_b && (beat_cnt_b != 16'hFFFF)) beat_cnt_b <= beat_cnt_b + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ping_pong_write_scheduler.sv
// Self-checking bench for ping_pong_write_scheduler: directed scenarios plus random traffic
// against a burst-level reference model; the saturation scenario needs PP_SCHED_STATS_EN.
module tb_ping_pong_write_scheduler;

  localparam int DW = 8;
  localparam int BL = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_a, req_b, valid_a, valid_b, write_full;
  logic [DW-1:0] data_a, data_b;
  logic          gnt_a, gnt_b, ready_a, ready_b, write_en, busy;
  logic [DW-1:0] write_data;
`ifdef PP_SCHED_STATS_EN
  logic [15:0]   beat_cnt_a, beat_cnt_b;
  logic          l_gnt_a, l_gnt_b, l_ready_a, l_ready_b, l_write_en, l_busy;
  logic [DW-1:0] l_write_data;
  logic [15:0]   l_beat_cnt_a, l_beat_cnt_b;
`endif

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: owner 0 = nobody, 1 = A, 2 = B.
  int            own;
  int            last;
  int            beats;
  bit            last_acc;
  int            m_cnt_a, m_cnt_b;
  logic [DW-1:0] wq[$];

  always #5 clk = ~clk;

  ping_pong_write_scheduler #(.DATA_W(DW), .BURST_LEN(BL)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .req_a      (req_a),
    .req_b      (req_b),
    .valid_a    (valid_a),
    .valid_b    (valid_b),
    .data_a     (data_a),
    .data_b     (data_b),
    .gnt_a      (gnt_a),
    .gnt_b      (gnt_b),
    .ready_a    (ready_a),
    .ready_b    (ready_b),
    .write_full (write_full),
    .write_en   (write_en),
    .write_data (write_data),
    .busy       (busy)
`ifdef PP_SCHED_STATS_EN
    ,
    .beat_cnt_a (beat_cnt_a),
    .beat_cnt_b (beat_cnt_b)
`endif
  );

`ifdef PP_SCHED_STATS_EN
  // Long-burst instance so the 16-bit saturation point is reachable in few cycles.
  ping_pong_write_scheduler #(.DATA_W(DW), .BURST_LEN(255)) u_dut_long (
    .clk        (clk),
    .rst        (rst),
    .req_a      (req_a),
    .req_b      (req_b),
    .valid_a    (valid_a),
    .valid_b    (valid_b),
    .data_a     (data_a),
    .data_b     (data_b),
    .gnt_a      (l_gnt_a),
    .gnt_b      (l_gnt_b),
    .ready_a    (l_ready_a),
    .ready_b    (l_ready_b),
    .write_full (write_full),
    .write_en   (l_write_en),
    .write_data (l_write_data),
    .busy       (l_busy),
    .beat_cnt_a (l_beat_cnt_a),
    .beat_cnt_b (l_beat_cnt_b)
  );
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    own = 0; last = 2; beats = 0; last_acc = 0;
    m_cnt_a = 0; m_cnt_b = 0;
  endtask

  task automatic model_step();
    bit acc, hreq, oreq;
    int nb;
    acc = !write_full && ((own == 1 && valid_a) || (own == 2 && valid_b));
    last_acc = acc;
    if (acc) begin
      wq.push_back(own == 1 ? data_a : data_b);
      if (own == 1 && m_cnt_a < 65535) m_cnt_a++;
      if (own == 2 && m_cnt_b < 65535) m_cnt_b++;
    end
    if (own == 0) begin
      if (req_a && req_b) own = (last == 1) ? 2 : 1;
      else if (req_a)     own = 1;
      else if (req_b)     own = 2;
      if (own != 0) begin last = own; beats = 0; end
    end else begin
      hreq = (own == 1) ? req_a : req_b;
      oreq = (own == 1) ? req_b : req_a;
      nb = beats + (acc ? 1 : 0);
      if (nb == BL || !hreq) begin
        beats = 0;
        if (oreq) begin own = 3 - own; last = own; end
        else own = 0;
      end else begin
        beats = nb;
      end
    end
  endtask

  task automatic check_all();
    logic          ea, eb, ew;
    logic [DW-1:0] ed;
    ea = (own == 1);
    eb = (own == 2);
    ew = !write_full && ((ea && valid_a) || (eb && valid_b));
    ed = ea ? data_a : (eb ? data_b : '0);
    chk("gnt_a", gnt_a, ea);
    chk("gnt_b", gnt_b, eb);
    chk("busy", busy, ea | eb);
    chk("ready_a", ready_a, ea && !write_full);
    chk("ready_b", ready_b, eb && !write_full);
    chk("write_en", write_en, ew);
    chk("write_data", write_data, ed);
`ifdef PP_SCHED_STATS_EN
    chk("beat_cnt_a", beat_cnt_a, m_cnt_a);
    chk("beat_cnt_b", beat_cnt_b, m_cnt_b);
`endif
  endtask

  task automatic half_check();
    @(negedge clk);
    check_all();
  endtask

  task automatic half_step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    req_a = 0; req_b = 0; valid_a = 0; valid_b = 0; write_full = 0;
    data_a = '0; data_b = '0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
`ifdef PP_SCHED_STATS_EN
    int s_beats, s_run;
    bit s_gnt;
`endif
    rst = 1'b1;
    idle_inputs();
    model_reset();
    #2;
    chk("rst_gnt_a", gnt_a, 1'b0);
    chk("rst_gnt_b", gnt_b, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_write_en", write_en, 1'b0);
    chk("rst_write_data", write_data, 8'h00);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single requester A, four beats 0x11..0x14, then idle.
    wq.delete();
    req_a = 1; valid_a = 1; data_a = 8'h11;
    for (int k = 0; k <= 4; k++) begin
      half_check();
      if (k >= 1) begin
        chk("s1_gnt_a", gnt_a, 1'b1);
        chk("s1_write_en", write_en, 1'b1);
        chk("s1_write_data", write_data, 8'h10 + k);
      end
      half_step();
      if (last_acc) data_a = data_a + 1'b1;
      if (k == 4) begin req_a = 0; valid_a = 0; end
    end
    half_check();
    chk("s1_busy_after", busy, 1'b0);
    half_step();
    chk("s1_beats", wq.size(), 4);
    for (int i = 0; i < wq.size() && i < 4; i++) chk("s1_data", wq[i], 8'h11 + i);

    // Both requesters held: A,B,A,B bursts of four with direct handoff.
    pulse_reset();
    req_a = 1; req_b = 1; valid_a = 1; valid_b = 1;
    for (int k = 0; k <= 16; k++) begin
      data_a = DW'($urandom);
      data_b = DW'($urandom);
      half_check();
      if (k >= 1) begin
        chk("s2_gnt_a", gnt_a, (((k - 1) / 4) % 2) == 0);
        chk("s2_gnt_b", gnt_b, (((k - 1) / 4) % 2) == 1);
      end
      half_step();
    end
    idle_inputs();

    // write_full held three cycles while beat 2 is offered.
    pulse_reset();
    wq.delete();
    req_a = 1; valid_a = 1; data_a = 8'h21;
    for (int k = 0; k <= 7; k++) begin
      write_full = (k >= 2 && k <= 4);
      half_check();
      if (k >= 2 && k <= 4) begin
        chk("s3_ready_a", ready_a, 1'b0);
        chk("s3_write_en", write_en, 1'b0);
      end
      half_step();
      if (last_acc) data_a = data_a + 1'b1;
    end
    idle_inputs();
    chk("s3_beats", wq.size(), 4);
    for (int i = 0; i < wq.size() && i < 4; i++) chk("s3_data", wq[i], 8'h21 + i);

    // A drops req after two beats; B takes over with a full fresh burst.
    pulse_reset();
    req_a = 1; valid_a = 1; req_b = 1; valid_b = 1;
    for (int k = 0; k <= 8; k++) begin
      data_a = DW'($urandom);
      data_b = DW'($urandom);
      if (k == 3) begin req_a = 0; valid_a = 0; end
      half_check();
      if (k == 3) chk("s4_gnt_a", gnt_a, 1'b1);
      if (k >= 4 && k <= 7) chk("s4_gnt_b", gnt_b, 1'b1);
      if (k == 8) chk("s4_busy_after", busy, 1'b0);
      half_step();
    end
    idle_inputs();

    // Asynchronous reset during beat 3, then a tie must go to A.
    pulse_reset();
    req_a = 1; valid_a = 1; req_b = 1; valid_b = 1;
    data_a = 8'h5A; data_b = 8'hA5;
    for (int k = 0; k <= 2; k++) begin
      half_check();
      half_step();
    end
    #2 rst = 1'b1;
    #1;
    chk("s5_gnt_a", gnt_a, 1'b0);
    chk("s5_gnt_b", gnt_b, 1'b0);
    chk("s5_busy", busy, 1'b0);
    chk("s5_ready_a", ready_a, 1'b0);
    chk("s5_write_en", write_en, 1'b0);
    chk("s5_write_data", write_data, 8'h00);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    half_check();
    half_step();
    half_check();
    chk("s5_tie_gnt_a", gnt_a, 1'b1);
    half_step();
    idle_inputs();

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      req_a      = ($urandom_range(0, 3) != 0);
      req_b      = ($urandom_range(0, 2) != 0);
      valid_a    = ($urandom_range(0, 3) != 0);
      valid_b    = ($urandom_range(0, 3) != 0);
      write_full = ($urandom_range(0, 4) == 0);
      data_a     = DW'($urandom);
      data_b     = DW'($urandom);
      half_check();
      half_step();
    end
    idle_inputs();

`ifdef PP_SCHED_STATS_EN
    // 0x10000+5 beats from A on the long-burst instance: counter saturates.
    pulse_reset();
    req_a = 1; valid_a = 1;
    s_beats = 0; s_run = 0; s_gnt = 0;
    while (s_beats < 32'h10005) begin
      data_a = DW'($urandom);
      half_check();
      half_step();
      if (s_gnt) begin
        s_beats++;
        s_run++;
        if (s_run == 255) s_gnt = 0;
      end else begin
        s_gnt = 1;
        s_run = 0;
      end
    end
    @(negedge clk);
    chk("s6_beat_cnt_a", l_beat_cnt_a, 16'hFFFF);
    chk("s6_beat_cnt_b", l_beat_cnt_b, 16'h0000);
    idle_inputs();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ping_pong_write_scheduler.md
PING_PONG_WRITE_SCHEDULER -- requirements
Module: ping_pong_write_scheduler

Interface
REQ-001 SHALL have parameter DATA_W, default 8, the beat width matching the ping-pong buffer write port.
REQ-002 SHALL have parameter BURST_LEN, default 4, the maximum beats per grant (legal range 1..255).
REQ-003 SHALL have port clk  in  1  single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports req_a, req_b  in  1 each  requester wants the write port.
REQ-006 SHALL have ports valid_a, valid_b  in  1 each  requester beat valid.
REQ-007 SHALL have ports data_a, data_b  in  DATA_W each  requester beat data.
REQ-008 SHALL have ports gnt_a, gnt_b  out  1 each  requester currently owns the port (registered).
REQ-009 SHALL have ports ready_a, ready_b  out  1 each  beat accepted this cycle if valid is high.
REQ-010 SHALL have port write_full  in  1  buffer write bank full (stall).
REQ-011 SHALL have port write_en  out  1  write strobe to the buffer.
REQ-012 SHALL have port write_data  out  DATA_W  data to the buffer.
REQ-013 SHALL have port busy  out  1  high whenever the state is not IDLE.

Function
REQ-014 FSM states SHALL be IDLE, GRANT_A and GRANT_B; gnt_a and gnt_b SHALL be the decodes of GRANT_A and GRANT_B.
REQ-015 From IDLE with exactly one req high, the FSM SHALL move to that requester's GRANT state on the next edge (1-cycle grant latency).
REQ-016 From IDLE with both reqs high, the FSM SHALL grant the requester not served last; the last-served pointer SHALL reset so that A wins the first tie.
REQ-017 ready_x SHALL equal (state==GRANT_x) && !write_full, combinationally.
REQ-018 write_en SHALL equal valid_x && ready_x of the granted requester, and write_data SHALL equal data_x of that requester (combinational, zero latency); write_data SHALL be 0 in IDLE.
REQ-019 The burst counter SHALL increment by one per accepted beat and clear on every grant change.
REQ-020 A grant SHALL end on the edge where the BURST_LEN-th beat is accepted, or on any edge where the holder's req is low.
REQ-021 At grant end, the FSM SHALL go directly to the other GRANT state if the other req is high; otherwise it SHALL go to IDLE.
REQ-022 When write_full is high, no beat SHALL be accepted and the burst counter SHALL hold; the grant SHALL persist while req stays high.
REQ-023 A requester SHALL never be granted in two consecutive bursts while the other req is continuously high (no starvation).

Reset
REQ-024 rst SHALL force state IDLE, burst counter 0, last-served pointer to "B" (so A wins the first tie), gnt_a/gnt_b/busy 0, and ready_a/ready_b/write_en/write_data 0.
REQ-025 rst asserted mid-burst SHALL abandon the burst; unaccepted beats SHALL NOT be replayed.

Configuration
REQ-026 With macro PP_SCHED_STATS_EN defined, the block SHALL add outputs beat_cnt_a and beat_cnt_b (16 bits each), each counting accepted beats, saturating at 0xFFFF and cleared by rst.
REQ-027 Without PP_SCHED_STATS_EN, those ports and counters SHALL be absent, and the behaviour of every other port SHALL be identical.

Structure
REQ-028 The state enum typedef and the burst-counter width constant SHALL reside in package ping_pong_sched_pkg.
REQ-029 The 2-way round-robin pick (inputs: reqs and last-served; output: winner) SHALL be sub-module pp_rr_pick.

Verification
REQ-030 Bench SHALL cover single requester A: req_a=1 and valid_a=1 with data 0x11..0x14 -> gnt_a one cycle later, write_en on 4 consecutive cycles with data 0x11..0x14, then IDLE.
REQ-031 Bench SHALL cover both reqs held high: grants alternate A,B,A,B, with bursts of exactly 4 beats, each GRANT_A/GRANT_B handoff direct with no IDLE cycle, and A first after reset.
REQ-032 Bench SHALL cover write_full high for 3 cycles during beat 2 of a burst: ready and write_en low for those cycles, then beats 2..4 complete with no data lost or duplicated.
REQ-033 Bench SHALL cover req_a dropped after beat 2 while req_b is high: GRANT_B on the next edge, and B's burst counter starts at 0.
REQ-034 Bench SHALL cover rst asserted mid-burst on beat 3: all outputs 0 immediately (asynchronous); after release, a tie grants A.
REQ-035 Bench SHALL cover PP_SCHED_STATS_EN defined: after 0x10000+5 beats from A, beat_cnt_a=0xFFFF and beat_cnt_b=0.
